// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: datapath widths, ALU operation codes,
// and the opcode/funct values the execute stage decodes.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_NOR  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

endpackage

// File: rtl/mips_alu_decode.sv
// Opcode/funct to ALU operation decode; purely combinational, zero latency.
// Unrecognised encodings (including syscall, loads and stores) fall back to ADD.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_ADDU, FN_SYSCALL: alu_op = ALU_ADD;
                FN_SUB, FN_SUBU:             alu_op = ALU_SUB;
                FN_AND:                      alu_op = ALU_AND;
                FN_OR:                       alu_op = ALU_OR;
                FN_XOR:                      alu_op = ALU_XOR;
                FN_NOR:                      alu_op = ALU_NOR;
                FN_SLT:                      alu_op = ALU_SLT;
                FN_SLTU:                     alu_op = ALU_SLTU;
                FN_SLL:                      alu_op = ALU_SLL;
                FN_SRL:                      alu_op = ALU_SRL;
                FN_SRA:                      alu_op = ALU_SRA;
                default:                     alu_op = ALU_ADD;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU:                 alu_op = ALU_ADD;
                OP_ANDI:                           alu_op = ALU_AND;
                OP_ORI:                            alu_op = ALU_OR;
                OP_XORI:                           alu_op = ALU_XOR;
                OP_SLTI:                           alu_op = ALU_SLT;
                OP_SLTIU:                          alu_op = ALU_SLTU;
                OP_LUI:                            alu_op = ALU_LUI;
                OP_BEQ, OP_BNE:                    alu_op = ALU_SUB;
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                OP_SB, OP_SH, OP_SW:               alu_op = ALU_ADD;
                default:                           alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mips_exe_mem_unit.sv
// Execute-stage ALU (combinational) feeding the EXE/MEM register (1-cycle latency).
// No handshake: write=0 stalls by holding the register; reset flushes it.
module mips_exe_mem_unit #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] oprd1,
    input  logic [DATA_W-1:0] oprd2,
    input  logic [4:0]        shamt,
    input  logic              syscall_e,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic              mem_write_e,
    input  logic              mem_read_e,
    input  logic              load_full_word_e,
    input  logic              load_signed_e,
    input  logic [DATA_W-1:0] reg_data2_e,
    input  logic [REG_AW-1:0] write_reg_e,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero,
    output logic              syscall_m,
    output logic              reg_write_m,
    output logic              mem_to_reg_m,
    output logic              mem_write_m,
    output logic              mem_read_m,
    output logic              load_full_word_m,
    output logic              load_signed_m,
    output logic [DATA_W-1:0] reg_data2_m,
    output logic [DATA_W-1:0] alu_result_m,
    output logic [REG_AW-1:0] write_reg_m
);
    import mips_pkg::*;

    mips_alu_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (alu_op)
    );

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_AND:  alu_result = oprd1 & oprd2;
            ALU_OR:   alu_result = oprd1 | oprd2;
            ALU_ADD:  alu_result = oprd1 + oprd2;
            ALU_XOR:  alu_result = oprd1 ^ oprd2;
            ALU_SLL:  alu_result = oprd2 << shamt;
            ALU_SRL:  alu_result = oprd2 >> shamt;
            ALU_SUB:  alu_result = oprd1 - oprd2;
            ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(oprd1) < $signed(oprd2)};
            ALU_SRA:  alu_result = DATA_W'($signed(oprd2) >>> shamt);
            ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, oprd1 < oprd2};
            ALU_LUI:  alu_result = oprd2 << 16;
            ALU_NOR:  alu_result = ~(oprd1 | oprd2);
            default:  alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == '0);

    // Reset wins over write so a flush cancels any pending store or register write.
    always_ff @(posedge clk) begin
        if (reset) begin
            syscall_m        <= 1'b0;
            reg_write_m      <= 1'b0;
            mem_to_reg_m     <= 1'b0;
            mem_write_m      <= 1'b0;
            mem_read_m       <= 1'b0;
            load_full_word_m <= 1'b0;
            load_signed_m    <= 1'b0;
            reg_data2_m      <= '0;
            alu_result_m     <= '0;
            write_reg_m      <= '0;
        end else if (write) begin
            syscall_m        <= syscall_e;
            reg_write_m      <= reg_write_e;
            mem_to_reg_m     <= mem_to_reg_e;
            mem_write_m      <= mem_write_e;
            mem_read_m       <= mem_read_e;
            load_full_word_m <= load_full_word_e;
            load_signed_m    <= load_signed_e;
            reg_data2_m      <= reg_data2_e;
            alu_result_m     <= alu_result;
            write_reg_m      <= write_reg_e;
        end
    end

endmodule

// File: tb/tb_mips_exe_mem_unit.sv
// Bench for mips_exe_mem_unit: directed vector table, hand-written pipeline
// sequences, then random traffic against a behavioural model.
module tb_mips_exe_mem_unit;

    logic        clk = 1'b0;
    logic        reset, write;
    logic [5:0]  opcode, funct;
    logic [31:0] oprd1, oprd2;
    logic [4:0]  shamt;
    logic        syscall_e, reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e;
    logic        load_full_word_e, load_signed_e;
    logic [31:0] reg_data2_e;
    logic [4:0]  write_reg_e;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        syscall_m, reg_write_m, mem_to_reg_m, mem_write_m, mem_read_m;
    logic        load_full_word_m, load_signed_m;
    logic [31:0] reg_data2_m, alu_result_m;
    logic [4:0]  write_reg_m;

    always #5 clk = ~clk;

    mips_exe_mem_unit dut (
        .clk(clk), .reset(reset), .write(write),
        .opcode(opcode), .funct(funct), .oprd1(oprd1), .oprd2(oprd2), .shamt(shamt),
        .syscall_e(syscall_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .mem_write_e(mem_write_e), .mem_read_e(mem_read_e),
        .load_full_word_e(load_full_word_e), .load_signed_e(load_signed_e),
        .reg_data2_e(reg_data2_e), .write_reg_e(write_reg_e),
        .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
        .syscall_m(syscall_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .mem_write_m(mem_write_m), .mem_read_m(mem_read_m),
        .load_full_word_m(load_full_word_m), .load_signed_m(load_signed_m),
        .reg_data2_m(reg_data2_m), .alu_result_m(alu_result_m), .write_reg_m(write_reg_m)
    );

    // Pipeline-register view: 7 control bits, store data, ALU result, dest reg.
    logic [75:0] act_m;
    assign act_m = {syscall_m, reg_write_m, mem_to_reg_m, mem_write_m, mem_read_m,
                    load_full_word_m, load_signed_m, reg_data2_m, alu_result_m, write_reg_m};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: decode tables indexed by funct/opcode, ADD where unlisted.
    logic [3:0] r_map [64];
    logic [3:0] i_map [64];

    function automatic logic [3:0] ref_op(input logic [5:0] opc, input logic [5:0] fn);
        return (opc == 6'h00) ? r_map[fn] : i_map[opc];
    endfunction

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        longint unsigned ua = a, ub = b, scale = 64'd1 << sh;
        longint          sa = int'(a), sb = int'(b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'(ua + ub);
            4'd3:  return a ^ b;
            4'd4:  return 32'(ub * scale);
            4'd5:  return 32'(ub / scale);
            4'd6:  return 32'(ua + (64'h1_0000_0000 - ub));
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return 32'(sb >>> sh);
            4'd9:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd10: return 32'(ub * 64'd65536);
            4'd12: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [3:0]  eop;
        logic [31:0] eres;
        logic        ez;
    } vec_t;

    vec_t vecs[20];

    task automatic set_ctrl(input logic [6:0] c, input logic [31:0] d2, input logic [4:0] wr);
        {syscall_e, reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e,
         load_full_word_e, load_signed_e} = c;
        reg_data2_e = d2;
        write_reg_e = wr;
    endtask

    logic [75:0] exp_m;
    logic [3:0]  mop;
    logic [31:0] mres;

    initial begin
        for (int i = 0; i < 64; i++) begin
            r_map[i] = 4'd2;
            i_map[i] = 4'd2;
        end
        r_map[6'h22] = 4'd6; r_map[6'h23] = 4'd6; r_map[6'h24] = 4'd0;
        r_map[6'h25] = 4'd1; r_map[6'h26] = 4'd3; r_map[6'h27] = 4'd12;
        r_map[6'h2A] = 4'd7; r_map[6'h2B] = 4'd9; r_map[6'h00] = 4'd4;
        r_map[6'h02] = 4'd5; r_map[6'h03] = 4'd8;
        i_map[6'h0C] = 4'd0; i_map[6'h0D] = 4'd1; i_map[6'h0E] = 4'd3;
        i_map[6'h0A] = 4'd7; i_map[6'h0B] = 4'd9; i_map[6'h0F] = 4'd10;
        i_map[6'h04] = 4'd6; i_map[6'h05] = 4'd6;

        vecs[0]  = '{6'h08, 6'h00, 32'h0,        32'hFFFFFFFD, 5'd0,  4'd2,  32'hFFFFFFFD, 1'b0};
        vecs[1]  = '{6'h00, 6'h02, 32'h0,        32'h5,        5'd1,  4'd5,  32'h2,        1'b0};
        vecs[2]  = '{6'h00, 6'h03, 32'h0,        32'h80000000, 5'd4,  4'd8,  32'hF8000000, 1'b0};
        vecs[3]  = '{6'h00, 6'h22, 32'h5,        32'h2,        5'd0,  4'd6,  32'h3,        1'b0};
        vecs[4]  = '{6'h04, 6'h00, 32'h7,        32'h7,        5'd0,  4'd6,  32'h0,        1'b1};
        vecs[5]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1,        5'd0,  4'd7,  32'h1,        1'b0};
        vecs[6]  = '{6'h00, 6'h2B, 32'hFFFFFFFF, 32'h1,        5'd0,  4'd9,  32'h0,        1'b1};
        vecs[7]  = '{6'h0F, 6'h00, 32'h0,        32'h1234,     5'd0,  4'd10, 32'h12340000, 1'b0};
        vecs[8]  = '{6'h00, 6'h27, 32'h0F0F0000, 32'h0000F0F0, 5'd0,  4'd12, 32'hF0F00F0F, 1'b0};
        vecs[9]  = '{6'h00, 6'h00, 32'h0,        32'h3,        5'd31, 4'd4,  32'h80000000, 1'b0};
        vecs[10] = '{6'h00, 6'h0C, 32'h1,        32'h2,        5'd0,  4'd2,  32'h3,        1'b0};
        vecs[11] = '{6'h00, 6'h21, 32'hFFFFFFFF, 32'h1,        5'd0,  4'd2,  32'h0,        1'b1};
        vecs[12] = '{6'h0D, 6'h00, 32'hF0,       32'h0F,       5'd0,  4'd1,  32'hFF,       1'b0};
        vecs[13] = '{6'h0E, 6'h00, 32'hFF,       32'h0F,       5'd0,  4'd3,  32'hF0,       1'b0};
        vecs[14] = '{6'h0C, 6'h00, 32'hFF,       32'h0F,       5'd0,  4'd0,  32'h0F,       1'b0};
        vecs[15] = '{6'h3F, 6'h00, 32'h2,        32'h3,        5'd0,  4'd2,  32'h5,        1'b0};
        vecs[16] = '{6'h05, 6'h00, 32'h0,        32'h1,        5'd0,  4'd6,  32'hFFFFFFFF, 1'b0};
        vecs[17] = '{6'h00, 6'h02, 32'h0,        32'h80000000, 5'd4,  4'd5,  32'h08000000, 1'b0};
        vecs[18] = '{6'h0A, 6'h00, 32'h80000000, 32'h0,        5'd0,  4'd7,  32'h1,        1'b0};
        vecs[19] = '{6'h0B, 6'h00, 32'h80000000, 32'h0,        5'd0,  4'd9,  32'h0,        1'b1};

        reset = 1'b1; write = 1'b0;
        opcode = 6'h00; funct = 6'h20; oprd1 = 32'h0; oprd2 = 32'h0; shamt = 5'd0;
        set_ctrl(7'h7F, 32'hDEADBEEF, 5'd31);

        // Reset state
        @(posedge clk); #1;
        chk("reset_clear", 80'(act_m), 80'd0);
        reset = 1'b0;

        // Combinational vectors with write=0: register must also stay cleared
        foreach (vecs[i]) begin
            opcode = vecs[i].opc; funct = vecs[i].fn;
            oprd1 = vecs[i].a; oprd2 = vecs[i].b; shamt = vecs[i].sh;
            #2;
            chk($sformatf("vec%0d_op", i),   80'(alu_op),     80'(vecs[i].eop));
            chk($sformatf("vec%0d_res", i),  80'(alu_result), 80'(vecs[i].eres));
            chk($sformatf("vec%0d_zero", i), 80'(alu_zero),   80'(vecs[i].ez));
        end
        @(posedge clk); #1;
        chk("hold_after_vectors", 80'(act_m), 80'd0);

        // sw: address 0+5 captured along with mem_write
        opcode = 6'h2B; funct = 6'h00; oprd1 = 32'h0; oprd2 = 32'h5; shamt = 5'd0;
        set_ctrl(7'b0001000, 32'h0, 5'd0);
        write = 1'b1;
        @(posedge clk); #1;
        chk("sw_alu_result_m", 80'(alu_result_m), 80'd5);
        chk("sw_mem_write_m", 80'(mem_write_m), 80'd1);
        exp_m = {7'b0001000, 32'h0, 32'h5, 5'd0};
        chk("sw_bundle", 80'(act_m), 80'(exp_m));

        // Stall: inputs change, register holds over two edges
        write = 1'b0;
        opcode = 6'h00; funct = 6'h25; oprd1 = 32'h1234; oprd2 = 32'h8;
        set_ctrl(7'b1110111, 32'hCAFEF00D, 5'd17);
        @(posedge clk); @(posedge clk); #1;
        chk("stall_hold", 80'(act_m), 80'(exp_m));

        // lw in flight, then reset together with write flushes it
        write = 1'b1;
        opcode = 6'h23; oprd1 = 32'h100; oprd2 = 32'h4;
        set_ctrl(7'b0110110, 32'h0, 5'd9);
        @(posedge clk); #1;
        exp_m = {7'b0110110, 32'h0, 32'h104, 5'd9};
        chk("lw_bundle", 80'(act_m), 80'(exp_m));
        reset = 1'b1;
        set_ctrl(7'b0101000, 32'h55, 5'd3);
        @(posedge clk); #1;
        chk("reset_with_write", 80'(act_m), 80'd0);
        reset = 1'b0; write = 1'b0;

        // Random traffic against the model
        exp_m = '0;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    opcode = 6'h00;
                2:       opcode = 6'($urandom);
                default: begin
                    logic [5:0] ops [12];
                    ops = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A,
                            6'h0B, 6'h0F, 6'h04, 6'h05, 6'h23, 6'h2B};
                    opcode = ops[$urandom_range(0, 11)];
                end
            endcase
            if ($urandom_range(0, 3) == 0) funct = 6'($urandom);
            else begin
                logic [5:0] fns [12];
                fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                        6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h03};
                funct = ($urandom_range(0, 11) == 0) ? 6'h02 : fns[$urandom_range(0, 11)];
            end
            oprd1 = $urandom;
            case ($urandom_range(0, 3))
                0:       oprd2 = oprd1;
                1:       oprd2 = 32'($urandom_range(0, 15));
                default: oprd2 = $urandom;
            endcase
            shamt = 5'($urandom);
            set_ctrl(7'($urandom), $urandom, 5'($urandom));
            write = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 15) == 0);
            #2;
            mop  = ref_op(opcode, funct);
            mres = ref_res(mop, oprd1, oprd2, shamt);
            chk($sformatf("rnd%0d_op", n),   80'(alu_op),     80'(mop));
            chk($sformatf("rnd%0d_res", n),  80'(alu_result), 80'(mres));
            chk($sformatf("rnd%0d_zero", n), 80'(alu_zero),   80'(mres == 32'd0));
            if (reset)
                exp_m = '0;
            else if (write)
                exp_m = {syscall_e, reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e,
                         load_full_word_e, load_signed_e, reg_data2_e, mres, write_reg_e};
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_m", n), 80'(act_m), 80'(exp_m));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_exe_mem_unit.md
Name: mips_exe_mem_unit

Overview:
- Execute-stage datapath slice of the 5-stage MIPS pipeline.
- Decodes opcode/funct into a 4-bit ALU operation and computes the 32-bit ALU result and zero flag combinationally.
- Latches the result and the memory/write-back control bundle into the EXE/MEM pipeline register.
- Sits between operand forwarding muxes (upstream) and data memory / forwarding unit (downstream).

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears the pipeline register
- write  in  1  pipeline-register load enable
- opcode  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- oprd1  in  DATA_W  ALU operand A (forwarded rs)
- oprd2  in  DATA_W  ALU operand B (rt or immediate)
- shamt  in  5  shift amount
- syscall_e, reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e, load_full_word_e, load_signed_e  in  1 each  stage-E control bits
- reg_data2_e  in  DATA_W  store data
- write_reg_e  in  REG_AW  destination register
- alu_op  out  4  decoded operation (combinational)
- alu_result  out  DATA_W  combinational result
- alu_zero  out  1  alu_result == 0
- syscall_m, reg_write_m, mem_to_reg_m, mem_write_m, mem_read_m, load_full_word_m, load_signed_m  out  1 each  registered
- reg_data2_m, alu_result_m  out  DATA_W  registered
- write_reg_m  out  REG_AW  registered

Behaviour:
- alu_op encoding:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT, 8 SRA, 9 SLTU, 10 LUI, 12 NOR.
  - 11, 13, 14, 15 produce result 0.
- R-type decode (opcode 0x00) by funct:
  - 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
  - 0x2A SLT; 0x2B SLTU; 0x00 SLL; 0x02 SRL; 0x03 SRA.
  - 0x0C (syscall) and any other funct decode to ADD.
- I-type decode by opcode:
  - 0x08/0x09 ADD; 0x0C AND; 0x0D OR; 0x0E XOR; 0x0A SLT; 0x0B SLTU; 0x0F LUI.
  - 0x04/0x05 SUB.
  - Loads 0x20/0x21/0x23/0x24/0x25 and stores 0x28/0x29/0x2B ADD.
  - Any other opcode ADD.
- Arithmetic, all modulo 2^32:
  - ADD/SUB wrap; no overflow trap.
  - SLT is a signed compare of oprd1 < oprd2; SLTU is unsigned. Both return 1 or 0.
- Shifts:
  - Operate on oprd2 by shamt; oprd1 is ignored.
  - SRL zero-fills; SRA sign-fills.
  - LUI = oprd2 << 16.
- Immediate extension is done upstream; this block uses oprd2 as given.
- alu_zero = (alu_result == 0) for every op, including SUB for beq.
- alu_op, alu_result and alu_zero are purely combinational from the inputs, with zero latency.
- Pipeline register, evaluated on rising clk:
  - reset=1: all _m outputs become 0. Reset has priority over write.
  - Else write=1: each _m output loads its _e input; alu_result_m loads alu_result.
  - Else: hold.
- Latency: one cycle from the _e inputs to the _m outputs.
- Reset asserted mid-stream flushes the in-flight instruction, so a pending mem_write_m or reg_write_m is cancelled.
- Before the first reset, register contents are undefined.

Decomposition:
- Shared package `mips_pkg`:
  - ALU op localparams (ALU_AND … ALU_NOR).
  - Opcode and funct constants.
  - DATA_W and REG_AW.
- Sub-modules:
  - `mips_alu_decode`: combinational opcode/funct → alu_op.
  - The ALU and the register stay inline in the top module.

Test Plan:
- opcode 0x08, oprd1=0, oprd2=0xFFFFFFFD → alu_op=2, alu_result=0xFFFFFFFD, alu_zero=0.
- R-type funct 0x02, oprd2=5, shamt=1 → alu_op=5, result=2.
- R-type funct 0x03, oprd2=0x80000000, shamt=4 → result=0xF8000000.
- R-type funct 0x22, oprd1=5, oprd2=2 → result=3.
- opcode 0x04, oprd1=oprd2=7 → alu_op=6, alu_zero=1.
- SLT vs SLTU:
  - oprd1=0xFFFFFFFF, oprd2=1 → SLT result 1.
  - Same operands → SLTU result 0.
- Pipeline register:
  - reset=1 for one edge → all _m outputs 0.
  - write=1 with sw (opcode 0x2B, oprd1=0, oprd2=5, reg_data2_e=0, mem_write_e=1) → next edge alu_result_m=5, mem_write_m=1.
  - write=0 → _m outputs hold across edges.
  - reset=1 together with write=1 → _m outputs cleared.
